tppe_join_scheduler: RTL and testbench

//  Sequences one TPPE inner-join pass. First gates the spike compressor for T_WINDOW valid samples.

---
 rtl/tppe_join_scheduler.sv | 119 +++++++++++
 tb/tb_tppe_join_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tppe_join_scheduler.sv
// TPPE inner-join pass sequencer: spike window gating, weight fetch/issue walk, pipeline drain.
// Optional stall counter enabled by defining TPPE_SCHED_PERF_EN.
module tppe_join_scheduler #(
  parameter int T_WINDOW        = 16,
  parameter int PARALLEL_FACTOR = 4,
  parameter int NEURON_ID_W     = 4,
  parameter int COL_ID_W        = 4,
  parameter int NUM_NEURONS     = 16,
  parameter int NUM_COLS        = 16,
  parameter int PIPE_LAT        = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   spike_vld,
  output logic                   shift_en,
  output logic                   wt_req,
  input  logic                   wt_ack,
  input  logic                   join_ready,
  output logic                   enable,
  output logic                   weight_valid,
  output logic [NEURON_ID_W-1:0] neuron_id,
  output logic [COL_ID_W-1:0]    col_base,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            stall_cnt
);
  localparam int CNT_W = $clog2(T_WINDOW) + 1;

  typedef enum logic [2:0] {IDLE, COLLECT, FETCH, ISSUE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]       smp_cnt;
  logic [COL_ID_W:0]      col_nxt;
  logic [NEURON_ID_W:0]   nrn_nxt;
  logic                   row_end, last_grp, issue, last_smp, start_pass;
  logic [PIPE_LAT-1:0]    vld_pipe;

  // One extra bit so NUM_COLS == 2**COL_ID_W compares without wrapping to 0.
  assign col_nxt    = {1'b0, col_base} + (COL_ID_W+1)'(PARALLEL_FACTOR);
  assign nrn_nxt    = {1'b0, neuron_id} + (NEURON_ID_W+1)'(1);
  assign row_end    = (col_nxt == (COL_ID_W+1)'(NUM_COLS));
  assign last_grp   = row_end && (nrn_nxt == (NEURON_ID_W+1)'(NUM_NEURONS));
  assign issue      = (state == ISSUE) && join_ready && !abort;
  assign last_smp   = (state == COLLECT) && spike_vld && (smp_cnt == CNT_W'(T_WINDOW-1));
  assign start_pass = (state == IDLE) && start && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start)      state_nxt = COLLECT;
        COLLECT: if (last_smp)   state_nxt = FETCH;
        FETCH:   if (wt_ack)     state_nxt = ISSUE;
        ISSUE:   if (join_ready) state_nxt = last_grp ? DRAIN : FETCH;
        DRAIN:   if (vld_pipe[PIPE_LAT-1]) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en     = 1'b0;
    wt_req       = 1'b0;
    enable       = 1'b0;
    weight_valid = 1'b0;
    busy         = (state != IDLE);
    done         = 1'b0;
    case (state)
      COLLECT: shift_en = spike_vld;
      FETCH:   begin wt_req = 1'b1; enable = 1'b1; end
      ISSUE:   begin enable = 1'b1; weight_valid = issue; end
      DRAIN:   begin enable = 1'b1; done = vld_pipe[PIPE_LAT-1] && !abort; end
      default: ;
    endcase
  end

  // vld_pipe tracks the final strobe through the join latency; its tail ends the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_cnt   <= '0;
      neuron_id <= '0;
      col_base  <= '0;
      vld_pipe  <= '0;
    end else if (state_nxt == IDLE) begin
      smp_cnt   <= '0;
      neuron_id <= '0;
      col_base  <= '0;
      vld_pipe  <= '0;
    end else begin
      if (state == COLLECT && spike_vld) smp_cnt <= smp_cnt + CNT_W'(1);
      if (issue) begin
        col_base <= row_end ? '0 : col_nxt[COL_ID_W-1:0];
        if (row_end) neuron_id <= nrn_nxt[NEURON_ID_W-1:0];
      end
      vld_pipe <= (vld_pipe << 1) | PIPE_LAT'(issue && last_grp);
    end
  end

`ifdef TPPE_SCHED_PERF_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                     stall_q <= '0;
    else if (start_pass)                                         stall_q <= '0;
    else if (state == ISSUE && !join_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tppe_join_scheduler.sv
// Scoreboard bench for tppe_join_scheduler: stimulus queues expected issue groups, a monitor checks strobes and done.
module tb_tppe_join_scheduler;
  logic        clk = 1'b0;
  logic        rst, start, abort, spike_vld, join_ready;
  logic        ack_q, ack_force, req_q;
  logic        shift_en, wt_req, enable, weight_valid, busy, done;
  logic [3:0]  neuron_id, col_base;
  logic [15:0] stall_cnt;
  wire         wt_ack = ack_q | ack_force;

  tppe_join_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .spike_vld(spike_vld),
    .shift_en(shift_en), .wt_req(wt_req), .wt_ack(wt_ack), .join_ready(join_ready),
    .enable(enable), .weight_valid(weight_valid), .neuron_id(neuron_id),
    .col_base(col_base), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int n; int c; } grp_t;
  grp_t exp_q[$];
  int   errors = 0, checks = 0;
  int   cyc = 0, last_strobe = -100, exp_done = 0, done_cnt = 0;

`ifdef TPPE_SCHED_PERF_EN
  localparam int EXP_STALL = 5;
`else
  localparam int EXP_STALL = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Weight memory model: acknowledge one cycle after wt_req is observed.
  always @(negedge clk) req_q = wt_req;
  always @(posedge clk) begin #1; ack_q = req_q; end

  // Monitor: every strobe pops one expected group; done must trail the last strobe by 2 cycles.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (weight_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got n=%0d c=%0d expected none", neuron_id, col_base);
        end else begin
          grp_t g;
          g = exp_q.pop_front();
          chk("strobe_grp", {neuron_id, col_base}, 32'(g.n * 16 + g.c));
        end
        last_strobe = cyc;
      end
      if (done) begin
        if (exp_done == 0) begin
          checks++; errors++;
          $display("FAIL spurious_done: got done=1 expected 0");
        end else begin
          exp_done--;
          chk("done_q_empty", exp_q.size(), 0);
          chk("done_latency", cyc - last_strobe, 2);
        end
        done_cnt++;
      end
    end
  end

  task automatic push_groups(input int count);
    for (int i = 0; i < count; i++) begin
      grp_t g;
      g.n = i / 4; g.c = (i % 4) * 4;
      exp_q.push_back(g);
    end
  endtask

  // Start a pass and feed the spike window; returns at the first FETCH cycle's negedge.
  task automatic do_pass(input bit gap, input bit noise);
    int k = 0;
    bit ph = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    ack_force = noise;
    while (k < 16) begin
      spike_vld = gap ? ph : 1'b1;
      ph = !ph;
      @(negedge clk);
      chk("shift_en", shift_en, spike_vld);
      chk("no_early_fetch", wt_req, 0);
      if (spike_vld) k++;
      tick();
    end
    spike_vld = 1'b0; ack_force = 1'b0;
    @(negedge clk);
    chk("fetch_entry", wt_req, 1);
    if (noise) begin
      start = 1'b1;
      repeat (50) tick();
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int t = 0;
    while (done_cnt == d0 && t < 3000) begin tick(); t++; end
    chk("done_seen", done_cnt != d0, 1);
    repeat (2) tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wt_req"}, wt_req, 0);
    chk({tag, "_enable"}, enable, 0);
    chk({tag, "_wv"}, weight_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_neuron"}, neuron_id, 0);
    chk({tag, "_col"}, col_base, 0);
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; abort = 1'b0; spike_vld = 1'b0;
    join_ready = 1'b1; ack_force = 1'b0; ack_q = 1'b0; req_q = 1'b0;
    repeat (3) tick();
    chk_idle("reset");
    chk("reset_shift_en", shift_en, 0);
    chk("reset_stall", stall_cnt, 0);
    rst = 1'b0; tick();

    // Reset asserted while stalled in ISSUE.
    join_ready = 1'b0;
    do_pass(1'b0, 1'b0);
    t = 0;
    do begin @(negedge clk); t++; end while (!(enable && !wt_req) && t < 20);
    chk("reach_issue", enable && !wt_req, 1);
    rst = 1'b1;
    tick();
    chk_idle("rst_mid");
    chk("rst_mid_stall", stall_cnt, 0);
    rst = 1'b0; join_ready = 1'b1; tick();

    // Full pass, continuous spikes.
    push_groups(64); exp_done++;
    do_pass(1'b0, 1'b0);
    wait_done();
    chk_idle("post_pass");

    // Gapped spikes.
    push_groups(64); exp_done++;
    do_pass(1'b1, 1'b0);
    wait_done();

    // Backpressure at (3,8) for five ISSUE cycles.
    push_groups(64); exp_done++;
    fork
      do_pass(1'b0, 1'b0);
      begin
        int w = 0;
        do begin @(negedge clk); w++; end while (!(neuron_id == 3 && col_base == 8 && wt_req) && w < 2000);
        chk("bp_reach", w < 2000, 1);
        join_ready = 1'b0;
        do @(negedge clk); while (wt_req);
        repeat (4) @(negedge clk);
        join_ready = 1'b1;
      end
    join
    wait_done();
    chk("stall_cnt", stall_cnt, EXP_STALL);

    // Abort while fetching (7,4): 29 groups issued before it, no done.
    push_groups(29);
    do_pass(1'b0, 1'b0);
    t = 0;
    while (!(neuron_id == 7 && col_base == 4 && wt_req) && t < 2000) begin @(negedge clk); t++; end
    chk("abort_reach", t < 2000, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    @(negedge clk);
    chk_idle("abort");
    chk("abort_q_empty", exp_q.size(), 0);
    repeat (5) tick();
    push_groups(64); exp_done++;
    do_pass(1'b0, 1'b0);
    wait_done();

    // start held while busy, wt_ack during COLLECT.
    push_groups(64); exp_done++;
    do_pass(1'b0, 1'b1);
    wait_done();
    chk("final_idle", busy, 0);
    chk("final_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
